// File: rtl/key_serializer.sv
// Serial key transmitter: syncs eight buttons, optionally debounces them per frame,
// and shifts one MSB-first word per line on skey. Optional debounce: KEYSER_DEBOUNCE_EN.
module key_serializer #(
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int CNT_W           = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       pvalid,
    input  logic [7:0] btn,
    output logic       skey,
    output logic [7:0] key_state
);
    logic [7:0] btn_meta_q;
    logic [7:0] btn_s_q;
    logic       vsync_q;
    logic       tick;
    logic [7:0] key_state_q, key_state_d;
    logic [7:0] tx_sr_q, tx_sr_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       tx_idle;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            btn_meta_q <= 8'hFF;
            btn_s_q    <= 8'hFF;
            vsync_q    <= 1'b0;
        end else begin
            btn_meta_q <= btn;
            btn_s_q    <= btn_meta_q;
            vsync_q    <= vsync;
        end
    end

    assign tick = vsync & ~vsync_q;

`ifdef KEYSER_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(DEBOUNCE_FRAMES);

    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];

    // A bit is accepted once its disagreement has survived CNT_LIM frame ticks.
    always_comb begin
        logic [CNT_W-1:0] cnt_inc;
        key_state_d = key_state_q;
        cnt_inc     = '0;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = cnt_q[i];
            cnt_inc  = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + 1'b1;
            if (btn_s_q[i] == key_state_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_inc >= CNT_LIM) begin
                    key_state_d[i] = btn_s_q[i];
                    cnt_d[i]       = '0;
                end else begin
                    cnt_d[i] = cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
        end
    end
`else
    logic unused_cfg;

    always_comb key_state_d = btn_s_q;

    assign unused_cfg = ^{tick, DEBOUNCE_FRAMES[0], CNT_W[0]};
`endif

    // Once eight bits are out the register is all ones, so holding equals shifting.
    assign tx_idle = (bit_cnt_q == 4'd8);

    always_comb begin
        tx_sr_d   = tx_sr_q;
        bit_cnt_d = bit_cnt_q;
        if (hsync) begin
            tx_sr_d   = key_state_q;
            bit_cnt_d = 4'd0;
        end else if (pvalid && !tx_idle) begin
            tx_sr_d   = {tx_sr_q[6:0], 1'b1};
            bit_cnt_d = bit_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_state_q <= 8'hFF;
            tx_sr_q     <= 8'hFF;
            bit_cnt_q   <= 4'd0;
        end else begin
            key_state_q <= key_state_d;
            tx_sr_q     <= tx_sr_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    assign skey      = tx_sr_q[7];
    assign key_state = key_state_q;
endmodule

// File: tb/tb_key_serializer.sv
// Directed bench for key_serializer: a receiver model captures each line's word and
// compares it against a queue of words expected when the line was launched.
module tb_key_serializer;
    logic       clk = 1'b0;
    logic       rstn;
    logic       hsync;
    logic       vsync;
    logic       pvalid;
    logic [7:0] btn;
    logic       skey;
    logic [7:0] key_state;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q [$];

    key_serializer #(.DEBOUNCE_FRAMES(3), .CNT_W(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .hsync     (hsync),
        .vsync     (vsync),
        .pvalid    (pvalid),
        .btn       (btn),
        .skey      (skey),
        .key_state (key_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic frame();
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Drive a new button word and wait long enough for it to be accepted.
    task automatic set_key(input logic [7:0] v);
        btn = v;
`ifdef KEYSER_DEBOUNCE_EN
        repeat (3) @(negedge clk);
        repeat (4) frame();
`else
        repeat (4) @(negedge clk);
`endif
    endtask

    // One line: 4 hsync cycles, then pvalid pulses separated by 'gap' idle cycles.
    task automatic run_line(input int gap, input int extra, input logic [7:0] mid_btn,
                            input int mid_at);
        logic [7:0] rx;
        logic [7:0] want;
        logic       held;
        rx    = 8'h00;
        hsync = 1'b1;
        repeat (4) @(negedge clk);
        hsync = 1'b0;
        for (int n = 0; n < 8 + extra; n++) begin
            pvalid = 1'b1;
            if (n < 8) rx = {rx[6:0], skey};
            else chk("skey_after_word", {31'd0, skey}, 32'd1);
            @(negedge clk);
            pvalid = 1'b0;
            if (n + 1 == mid_at) btn = mid_btn;
            held = skey;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk("skey_gap_hold", {31'd0, skey}, {31'd0, held});
            end
        end
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            want = exp_q.pop_front();
            chk("rx_word", {24'd0, rx}, {24'd0, want});
        end
        $display("line: rx=%02h gap=%0d", rx, gap);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; btn = 8'h00; hsync = 1'b0; vsync = 1'b0; pvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_skey", {31'd0, skey}, 32'd1);
        chk("reset_key_state", {24'd0, key_state}, 32'hFF);
        rstn = 1'b1;
        set_key(8'h00);
        chk("key_after_reset", {24'd0, key_state}, 32'h00);

        // Framing: full word then ones on extra pvalid cycles.
        set_key(8'hA5);
        chk("key_a5", {24'd0, key_state}, 32'hA5);
        exp_q.push_back(8'hA5);
        run_line(0, 3, 8'h00, 0);

        // Gapped pvalid: 1,0,0,1,...
        set_key(8'h3C);
        exp_q.push_back(8'h3C);
        run_line(2, 1, 8'h00, 0);

`ifndef KEYSER_DEBOUNCE_EN
        // Mid-line change does not disturb the word in flight.
        set_key(8'hFF);
        exp_q.push_back(8'hFF);
        run_line(0, 1, 8'h7F, 3);
        chk("key_after_mid", {24'd0, key_state}, 32'h7F);
        exp_q.push_back(8'h7F);
        run_line(0, 1, 8'h00, 0);
`else
        // Debounce: a 2-frame glitch is rejected, a 3-frame change is accepted.
        set_key(8'hFF);
        btn = 8'hFE;
        repeat (3) @(negedge clk);
        repeat (2) frame();
        btn = 8'hFF;
        repeat (3) @(negedge clk);
        chk("glitch_rejected", {31'd0, key_state[0]}, 32'd1);
        frame();
        chk("glitch_still_rejected", {24'd0, key_state}, 32'hFF);
        btn = 8'hFE;
        repeat (3) @(negedge clk);
        repeat (2) frame();
        chk("hold_two_frames", {24'd0, key_state}, 32'hFF);
        vsync = 1'b1;
        @(negedge clk);
        chk("accept_third_tick", {24'd0, key_state}, 32'hFE);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.push_back(8'hFE);
        run_line(0, 1, 8'h00, 0);
`endif

        // Reset mid-word: five zeros shifted, then asynchronous reset.
        set_key(8'h00);
        hsync = 1'b1;
        repeat (4) @(negedge clk);
        hsync  = 1'b0;
        pvalid = 1'b1;
        repeat (5) @(negedge clk);
        chk("skey_before_reset", {31'd0, skey}, 32'd0);
        #2 rstn = 1'b0;
        #1;
        chk("skey_async_reset", {31'd0, skey}, 32'd1);
        chk("key_async_reset", {24'd0, key_state}, 32'hFF);
        @(negedge clk);
        pvalid = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        set_key(8'h00);
        exp_q.push_back(8'h00);
        run_line(0, 1, 8'h00, 0);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
